// File: rtl/if_id_pipe_reg_pkg.sv
// Shared defaults and FSM encoding for the CPU pipeline-register family.
package cp_pipe_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 16;
    localparam int unsigned INSTR_WIDTH_DEF = 16;
    localparam int unsigned NOP_INSTR_DEF   = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch/decode handshake bundle for the IF/ID register; master is the environment, slave the stage.
interface if_id_pipe_reg_if
    import cp_pipe_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF
);
    logic                   validIn;
    logic                   readyIn;
    logic [ADDR_WIDTH-1:0]  adder1In;
    logic [INSTR_WIDTH-1:0] instructionIn;
    logic                   validOut;
    logic                   readyOut;
    logic [ADDR_WIDTH-1:0]  adder1Out;
    logic [INSTR_WIDTH-1:0] instructionOut;

    modport master (
        output validIn, adder1In, instructionIn, readyOut,
        input  readyIn, validOut, adder1Out, instructionOut
    );

    modport slave (
        input  validIn, adder1In, instructionIn, readyOut,
        output readyIn, validOut, adder1Out, instructionOut
    );
endinterface

// File: rtl/if_id_pipe_reg_slot.sv
// Width-parametrised data register with valid flag; clear wins over load.
module pipe_slot #(
    parameter int unsigned  W       = 32,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_valid
);
    logic [W-1:0] r_q;
    logic         r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= CLR_VAL;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_q     <= CLR_VAL;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_q     <= i_d;
            r_valid <= 1'b1;
        end
    end

    assign o_q     = r_q;
    assign o_valid = r_valid;
endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake, main+skid storage, synchronous flush.
module if_id_pipe_reg
    import cp_pipe_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned            INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_INSTR_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    if_id_pipe_reg_if.slave bus
);
    localparam int unsigned  W        = ADDR_WIDTH + INSTR_WIDTH;
    localparam logic [W-1:0] SLOT_CLR = {{ADDR_WIDTH{1'b0}}, NOP_INSTR};

    pipe_state_t  r_state, w_next;
    logic         r_ready;
    logic         w_acc, w_out;
    logic         w_main_load, w_main_clear, w_skid_load, w_skid_clear;
    logic         w_main_valid, w_skid_valid;
    logic [W-1:0] w_in_data, w_main_d, w_main_q, w_skid_q;

    assign w_in_data = {bus.adder1In, bus.instructionIn};
    assign w_acc     = bus.validIn & r_ready;
    assign w_out     = w_main_valid & bus.readyOut;
    // Skid is only occupied in TWO, so its valid flag selects the refill source.
    assign w_main_d  = w_skid_valid ? w_skid_q : w_in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != ST_TWO);
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_acc) w_next = ST_ONE;
                ST_ONE: begin
                    if (w_acc && !w_out)      w_next = ST_TWO;
                    else if (!w_acc && w_out) w_next = ST_EMPTY;
                end
                ST_TWO:   if (w_out) w_next = ST_ONE;
                default:  w_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: w_main_load = w_acc;
                ST_ONE: begin
                    w_main_load  = w_acc & w_out;
                    w_main_clear = !w_acc & w_out;
                    w_skid_load  = w_acc & !w_out;
                end
                ST_TWO: begin
                    w_main_load  = w_out;
                    w_skid_clear = w_out;
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(.W(W), .CLR_VAL(SLOT_CLR)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_main_clear),
        .i_load  (w_main_load),
        .i_d     (w_main_d),
        .o_q     (w_main_q),
        .o_valid (w_main_valid)
    );

    pipe_slot #(.W(W), .CLR_VAL(SLOT_CLR)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_skid_clear),
        .i_load  (w_skid_load),
        .i_d     (w_in_data),
        .o_q     (w_skid_q),
        .o_valid (w_skid_valid)
    );

    assign bus.readyIn                       = r_ready;
    assign bus.validOut                      = w_main_valid;
    assign {bus.adder1Out, bus.instructionOut} = w_main_q;
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: default build and an 8/32-bit build with NOP 0x13 driven in lockstep.
module tb_if_id_pipe_reg;

    logic clk;
    logic rst;
    logic flush;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    if_id_pipe_reg_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) bus_a ();
    if_id_pipe_reg_if #(.ADDR_WIDTH(8),  .INSTR_WIDTH(32)) bus_b ();

    if_id_pipe_reg #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .NOP_INSTR(16'h0)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus_a)
    );

    if_id_pipe_reg #(.ADDR_WIDTH(8), .INSTR_WIDTH(32), .NOP_INSTR(32'h13)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic        fl;
        logic        v;
        logic [15:0] ins;
        logic        ro;
        logic        ev;
        logic        er;
        logic [15:0] ei;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] ins;
    } item_t;

    vec_t  vecs [19];
    item_t model_q [$];

    function automatic logic [15:0] mkaddr(input logic [15:0] ins);
        return ins ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic v, input logic [15:0] ins,
                         input logic [15:0] addr, input logic ro);
        flush               = fl;
        bus_a.validIn       = v;
        bus_a.instructionIn = ins;
        bus_a.adder1In      = addr;
        bus_a.readyOut      = ro;
        bus_b.validIn       = v;
        bus_b.instructionIn = {ins, ~ins};
        bus_b.adder1In      = addr[7:0];
        bus_b.readyOut      = ro;
    endtask

    // Expected empty view: A shows 0/0, B shows addr 0 and NOP 0x13.
    task automatic check_both(input string tag, input logic ev, input logic er,
                              input logic [15:0] ei, input logic [15:0] ea);
        logic [15:0] ea_a;
        logic [31:0] ei_b;
        ea_a = ev ? ea : 16'h0;
        ei_b = ev ? {ei, ~ei} : 32'h13;
        chk({tag, " A.validOut"},       {63'b0, bus_a.validOut},       {63'b0, ev});
        chk({tag, " A.readyIn"},        {63'b0, bus_a.readyIn},        {63'b0, er});
        chk({tag, " A.instructionOut"}, {48'b0, bus_a.instructionOut}, {48'b0, (ev ? ei : 16'h0)});
        chk({tag, " A.adder1Out"},      {48'b0, bus_a.adder1Out},      {48'b0, ea_a});
        chk({tag, " B.validOut"},       {63'b0, bus_b.validOut},       {63'b0, ev});
        chk({tag, " B.readyIn"},        {63'b0, bus_b.readyIn},        {63'b0, er});
        chk({tag, " B.instructionOut"}, {32'b0, bus_b.instructionOut}, {32'b0, ei_b});
        chk({tag, " B.adder1Out"},      {56'b0, bus_b.adder1Out},      {56'b0, ea_a[7:0]});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        v, ro, fl, r, acc, out, m_ready;
        logic [15:0] ins, addr;
        item_t       it;

        // readyOut=1 streaming, readyOut=0 fill to TWO, flush in TWO, flush with validIn, flush with out
        vecs[0]  = '{1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b1, 16'h1111};
        vecs[1]  = '{1'b0, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b1, 16'h2222};
        vecs[2]  = '{1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 16'h3333};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h1111};
        vecs[5]  = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h1111};
        vecs[6]  = '{1'b0, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 16'h1111};
        vecs[7]  = '{1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 16'h2222};
        vecs[8]  = '{1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 16'h3333};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b1, 16'h5555};
        vecs[11] = '{1'b0, 1'b1, 16'h6666, 1'b0, 1'b1, 1'b0, 16'h5555};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[14] = '{1'b1, 1'b1, 16'h4444, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[16] = '{1'b0, 1'b1, 16'h7777, 1'b0, 1'b1, 1'b1, 16'h7777};
        vecs[17] = '{1'b1, 1'b1, 16'h8888, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};

        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        #12;
        check_both("reset", 1'b0, 1'b1, 16'h0, 16'h0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].fl, vecs[i].v, vecs[i].ins, mkaddr(vecs[i].ins), vecs[i].ro);
            tick();
            check_both($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ei, mkaddr(vecs[i].ei));
        end

        // Asynchronous reset while in TWO takes effect before the next edge
        drive(1'b0, 1'b1, 16'hAAAA, mkaddr(16'hAAAA), 1'b0);
        tick();
        check_both("pre_rst1", 1'b1, 1'b1, 16'hAAAA, mkaddr(16'hAAAA));
        drive(1'b0, 1'b1, 16'hBBBB, mkaddr(16'hBBBB), 1'b0);
        tick();
        check_both("pre_rst2", 1'b1, 1'b0, 16'hAAAA, mkaddr(16'hAAAA));
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        #2 rst = 1'b1;
        #1 check_both("rst_async", 1'b0, 1'b1, 16'h0, 16'h0);
        #1 rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        check_both("post_rst", 1'b0, 1'b1, 16'h0, 16'h0);

        // Randomized traffic against a queue model of the stage contents
        model_q.delete();
        m_ready = 1'b1;
        v = 1'b0;
        ins = '0;
        addr = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(v && !m_ready)) begin
                v    = ($urandom_range(0, 3) != 0);
                ins  = 16'($urandom);
                addr = 16'($urandom);
            end
            ro = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 24) == 0);
            r  = ($urandom_range(0, 59) == 0);
            drive(fl, v, ins, addr, ro);
            rst = r;
            tick();
            if (r) begin
                model_q.delete();
                m_ready = 1'b1;
                v = 1'b0;
            end else if (fl) begin
                model_q.delete();
                m_ready = 1'b1;
                v = 1'b0;
            end else begin
                acc = v & m_ready;
                out = (model_q.size() > 0) & ro;
                if (out) void'(model_q.pop_front());
                if (acc) begin
                    it.addr = addr;
                    it.ins  = ins;
                    model_q.push_back(it);
                    v = 1'b0;
                end
                m_ready = (model_q.size() < 2);
            end
            rst = 1'b0;
            if (model_q.size() > 0)
                check_both($sformatf("rand%0d", n), 1'b1, m_ready, model_q[0].ins, model_q[0].addr);
            else
                check_both($sformatf("rand%0d", n), 1'b0, m_ready, 16'h0, 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
